proj_fm_minhash_scan: RTL and testbench

//  Downstream consumer of the double-buffered fragment memory (FM). Waits for the FM write buffer to fill,

---
 rtl/proj_pkg.sv | 20 ++
 rtl/proj_minhash_fold.sv | 55 +++++
 rtl/proj_fm_minhash_scan.sv | 158 +++++++++++++++
 tb/tb_proj_fm_minhash_scan.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared widths, minhash constants and scan FSM states
// Purpose: constants for the FM index/fragment widths and the minhash, plus
//          the scan state enum used by proj_fm_minhash_scan.
// Ports:   none (package).
package proj_pkg;
  localparam int SIGNED_INDICE_LEN         = 8;
  localparam int FM_EXTENDER_FRAG_LEN_BITS = 72;
  localparam int MINHASH_BITS              = 32;
  localparam logic [MINHASH_BITS-1:0] MINHASH_MUL  = 32'h9E3779B1;
  localparam logic [MINHASH_BITS-1:0] MINHASH_SEED = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FULL,
    SWAP,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;
endpackage

// File: rtl/proj_minhash_fold.sv
// rtl/proj_minhash_fold.sv - registered fold/multiply/seed hash stage
// Purpose: XOR-folds a fragment into HASH_BITS chunks (last chunk zero-extended),
//          multiplies by HASH_MUL mod 2^HASH_BITS, XORs HASH_SEED, registers result.
// Ports:   i_clk, i_rst (async active-high)
//          i_valid, i_data  : fragment in (S1)
//          o_valid, o_hash  : hash out (S2), one cycle later
module proj_minhash_fold
  import proj_pkg::*;
#(
  parameter int                   FRAG_LEN  = FM_EXTENDER_FRAG_LEN_BITS,
  parameter int                   HASH_BITS = MINHASH_BITS,
  parameter logic [HASH_BITS-1:0] HASH_MUL  = MINHASH_MUL,
  parameter logic [HASH_BITS-1:0] HASH_SEED = MINHASH_SEED
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [FRAG_LEN-1:0]  i_data,
  output logic                 o_valid,
  output logic [HASH_BITS-1:0] o_hash
);
  localparam int N_CHUNKS = (FRAG_LEN + HASH_BITS - 1) / HASH_BITS;
  localparam int PAD_LEN  = N_CHUNKS * HASH_BITS;

  logic [PAD_LEN-1:0]   w_padded;
  logic [HASH_BITS-1:0] w_fold;
  logic [HASH_BITS-1:0] w_hash;
  logic                 r_valid;
  logic [HASH_BITS-1:0] r_hash;

  // Zero-extension supplies the zero padding of the final partial chunk.
  assign w_padded = PAD_LEN'(i_data);

  always_comb begin
    w_fold = '0;
    for (int c = 0; c < N_CHUNKS; c++) begin
      w_fold = w_fold ^ w_padded[c*HASH_BITS +: HASH_BITS];
    end
  end

  assign w_hash = (w_fold * HASH_MUL) ^ HASH_SEED;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_hash  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_hash <= w_hash;
    end
  end

  assign o_valid = r_valid;
  assign o_hash  = r_hash;
endmodule

// File: rtl/proj_fm_minhash_scan.sv
// rtl/proj_fm_minhash_scan.sv - FM fragment sweep with running minimum hash
// Purpose: waits for the FM write buffer to fill, pulses o_chg_idx, sweeps
//          o_frag_idx over start_idx..start_idx+num_frags-1 and reports the
//          minimum hash and its index over a valid/ready handshake.
// Option:  PROJ_MINHASH_PAD_SKIP_EN - negative (zero-padded) indices never update min.
// Ports:   i_clk, i_rst (async active-high)
//          i_start, i_start_idx, i_num_frags : scan request (taken in IDLE only)
//          i_fm_wait, i_fm_rdata / o_frag_idx, o_chg_idx : FM interface
//          o_busy : not IDLE
//          o_res_valid, i_res_ready, o_res_hash, o_res_idx, o_res_empty : result
module proj_fm_minhash_scan
  import proj_pkg::*;
#(
  parameter int                   SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN,
  parameter int                   FRAG_LEN          = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
  parameter int                   CNT_BITS          = 16,
  parameter int                   HASH_BITS         = proj_pkg::MINHASH_BITS,
  parameter logic [HASH_BITS-1:0] HASH_MUL          = proj_pkg::MINHASH_MUL,
  parameter logic [HASH_BITS-1:0] HASH_SEED         = proj_pkg::MINHASH_SEED
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [SIGNED_INDICE_LEN-1:0] i_start_idx,
  input  logic [CNT_BITS-1:0]          i_num_frags,
  input  logic                         i_fm_wait,
  input  logic [FRAG_LEN-1:0]          i_fm_rdata,
  output logic [SIGNED_INDICE_LEN-1:0] o_frag_idx,
  output logic                         o_chg_idx,
  output logic                         o_busy,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic [HASH_BITS-1:0]         o_res_hash,
  output logic [SIGNED_INDICE_LEN-1:0] o_res_idx,
  output logic                         o_res_empty
);
  localparam logic [CNT_BITS-1:0] CNT_ONE    = 1;
  localparam logic [CNT_BITS-1:0] DRAIN_LAST = 2;

  scan_state_t                  r_state, w_next;
  logic [SIGNED_INDICE_LEN-1:0] r_start_idx, r_frag_idx, r_min_idx, r_s1_idx, r_s2_idx;
  logic [SIGNED_INDICE_LEN-1:0] w_scan_idx;
  logic [CNT_BITS-1:0]          r_num, r_cnt;
  logic [HASH_BITS-1:0]         r_min;
  logic                         r_hit;
  logic                         r_s1_valid;
  logic [FRAG_LEN-1:0]          r_s1_data;
  logic                         w_s2_valid;
  logic [HASH_BITS-1:0]         w_s2_hash;
  logic                         w_scan_last, w_drain_last, w_pad_ok, w_take;

  // Truncating the counter gives the sign-wrapping index add for free.
  assign w_scan_idx   = r_start_idx + SIGNED_INDICE_LEN'(r_cnt);
  assign w_scan_last  = (r_cnt == r_num - CNT_ONE);
  assign w_drain_last = (r_cnt == DRAIN_LAST);

`ifdef PROJ_MINHASH_PAD_SKIP_EN
  assign w_pad_ok = ~r_s2_idx[SIGNED_INDICE_LEN-1];
`else
  assign w_pad_ok = 1'b1;
`endif

  // Strict less-than keeps the earliest index on ties.
  assign w_take = w_s2_valid & w_pad_ok & (w_s2_hash < r_min);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_chg_idx   = 1'b0;
    o_busy      = (r_state != IDLE);
    o_res_valid = 1'b0;
    o_res_empty = 1'b0;
    o_frag_idx  = r_frag_idx;
    case (r_state)
      IDLE:      if (i_start) w_next = WAIT_FULL;
      WAIT_FULL: if (i_fm_wait) w_next = SWAP;
      SWAP: begin
        o_chg_idx = 1'b1;
        w_next    = (r_num == '0) ? DRAIN : SCAN;
      end
      SCAN: begin
        o_frag_idx = w_scan_idx;
        if (w_scan_last) w_next = DRAIN;
      end
      DRAIN:     if (w_drain_last) w_next = DONE;
      DONE: begin
        o_res_valid = 1'b1;
        o_res_empty = ~r_hit;
        if (i_res_ready) w_next = IDLE;
      end
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_start_idx <= '0;
      r_num       <= '0;
      r_cnt       <= '0;
      r_frag_idx  <= '0;
      r_min       <= '1;
      r_min_idx   <= '0;
      r_hit       <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_idx    <= '0;
      r_s2_idx    <= '0;
    end else begin
      r_s1_valid <= (r_state == SCAN);
      if (r_state == SCAN) begin
        r_s1_data  <= i_fm_rdata;
        r_s1_idx   <= w_scan_idx;
        r_frag_idx <= w_scan_idx;
      end
      // Index rides alongside the fold register so S2 hash and index line up.
      r_s2_idx <= r_s1_idx;
      case (r_state)
        IDLE: if (i_start) begin
          r_start_idx <= i_start_idx;
          r_num       <= i_num_frags;
          r_min       <= '1;
          r_min_idx   <= i_start_idx;
          r_hit       <= 1'b0;
        end
        SWAP:  r_cnt <= '0;
        SCAN:  r_cnt <= w_scan_last ? '0 : r_cnt + CNT_ONE;
        DRAIN: r_cnt <= r_cnt + CNT_ONE;
        default: ;
      endcase
      if (w_take) begin
        r_min     <= w_s2_hash;
        r_min_idx <= r_s2_idx;
        r_hit     <= 1'b1;
      end
    end
  end

  proj_minhash_fold #(
    .FRAG_LEN  (FRAG_LEN),
    .HASH_BITS (HASH_BITS),
    .HASH_MUL  (HASH_MUL),
    .HASH_SEED (HASH_SEED)
  ) u_fold (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (r_s1_valid),
    .i_data  (r_s1_data),
    .o_valid (w_s2_valid),
    .o_hash  (w_s2_hash)
  );

  assign o_res_hash = r_min;
  assign o_res_idx  = r_min_idx;
endmodule

// File: tb/tb_proj_fm_minhash_scan.sv
// tb/tb_proj_fm_minhash_scan.sv - scoreboard bench for proj_fm_minhash_scan
module tb_proj_fm_minhash_scan;
  import proj_pkg::*;
  localparam int IL = SIGNED_INDICE_LEN;
  localparam int FL = FM_EXTENDER_FRAG_LEN_BITS;
  localparam int HB = MINHASH_BITS;
  localparam int CB = 16;

  typedef struct {
    logic [HB-1:0] h;
    logic [IL-1:0] idx;
    logic          empty;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_chg = 0;

  logic          clk = 0, rst = 0, start = 0, fm_wait = 0, res_ready = 0;
  logic [IL-1:0] start_idx = '0;
  logic [CB-1:0] num_frags = '0;
  logic [FL-1:0] fm_rdata;
  logic [IL-1:0] frag_idx, res_idx;
  logic          chg_idx, busy, res_valid, res_empty;
  logic [HB-1:0] res_hash;
  logic [FL-1:0] mem [128];

  always #5 clk = ~clk;

  // FM stand-in: negative indices read as zero padding.
  always_comb fm_rdata = frag_idx[IL-1] ? '0 : mem[frag_idx[IL-2:0]];

  proj_fm_minhash_scan dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_idx(start_idx),
    .i_num_frags(num_frags), .i_fm_wait(fm_wait), .i_fm_rdata(fm_rdata),
    .o_frag_idx(frag_idx), .o_chg_idx(chg_idx), .o_busy(busy),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_hash(res_hash),
    .o_res_idx(res_idx), .o_res_empty(res_empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HB-1:0] ref_hash(input logic [FL-1:0] d);
    logic [HB-1:0] f;
    logic [63:0]   p;
    f = '0;
    for (int c = 0; c < FL; c += HB) f = f ^ HB'(d >> c);
    p = 64'(f) * 64'(MINHASH_MUL);
    return p[HB-1:0] ^ MINHASH_SEED;
  endfunction

  function automatic exp_t ref_scan(input logic [IL-1:0] s, input int n);
    exp_t          e;
    logic [IL-1:0] i;
    logic [FL-1:0] d;
    logic [HB-1:0] h;
    logic          skip;
    e.h = '1; e.idx = s; e.empty = 1'b1;
    for (int k = 0; k < n; k++) begin
      i = s + IL'(k);
      d = i[IL-1] ? '0 : mem[i[IL-2:0]];
      h = ref_hash(d);
      skip = 1'b0;
`ifdef PROJ_MINHASH_PAD_SKIP_EN
      skip = i[IL-1];
`endif
      if (!skip && h < e.h) begin
        e.h = h; e.idx = i; e.empty = 1'b0;
      end
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on every accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && chg_idx) n_chg++;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(res_valid), 64'(0));
      else begin
        e = sb.pop_front();
        chk("res_hash", 64'(res_hash), 64'(e.h));
        chk("res_idx", 64'(res_idx), 64'(e.idx));
        chk("res_empty", 64'(res_empty), 64'(e.empty));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_job(input logic [IL-1:0] s, input int n, input int wait_cyc, input int hold);
    int   cyc;
    int   chg0;
    exp_t e;
    e = ref_scan(s, n);
    tick();
    start = 1; start_idx = s; num_frags = CB'(n);
    sb.push_back(e);
    tick();
    start = 0;
    chg0 = n_chg;
    for (int j = 0; j < wait_cyc; j++) tick();
    if (wait_cyc > 0) begin
      chk("no_swap_while_not_full", 64'(n_chg - chg0), 64'(0));
      chk("busy_in_wait_full", 64'(busy), 64'(1));
    end
    fm_wait = 1;
    cyc = 0;
    while (!res_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    fm_wait = 0;
    chk("res_valid_seen", 64'(res_valid), 64'(1));
    chk("latency", 64'(cyc), 64'(5 + n));
    chk("chg_pulses", 64'(n_chg - chg0), 64'(1));
    for (int j = 0; j < hold; j++) begin
      start = 1;
      tick();
      chk("hold_valid", 64'(res_valid), 64'(1));
      chk("hold_hash", 64'(res_hash), 64'(e.h));
      chk("hold_idx", 64'(res_idx), 64'(e.idx));
      chk("hold_empty", 64'(res_empty), 64'(e.empty));
    end
    res_ready = 1;
    start = (hold > 0);
    tick();
    res_ready = 0;
    start = 0;
    chk("idle_after_accept", 64'(busy), 64'(0));
    if (hold > 0) begin
      tick();
      chk("start_ignored", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    #1 rst = 1;
    tick(); tick(); tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(res_valid), 64'(0));
    chk("rst_chg", 64'(chg_idx), 64'(0));
    chk("rst_frag_idx", 64'(frag_idx), 64'(0));
    chk("rst_hash", 64'(res_hash), 64'({HB{1'b1}}));
    chk("rst_idx", 64'(res_idx), 64'(0));
    chk("rst_empty", 64'(res_empty), 64'(0));
    rst = 0;

    // Long wait in WAIT_FULL, all-zero fragments.
    run_job(8'd0, 4, 10, 0);

    // Smallest hash at 2, tie at 5.
    for (int i = 0; i < 128; i++) mem[i] = FL'({$urandom, $urandom, $urandom}) | FL'(1);
    mem[2] = '0; mem[5] = '0;
    run_job(8'd0, 8, 2, 0);

    // Window starting in the padded region.
    mem[0] = FL'({$urandom, $urandom, $urandom}) | FL'(1);
    run_job(8'hFE, 3, 1, 0);

    // Empty scan with back-pressure and ignored starts.
    run_job(8'd7, 0, 0, 5);

    // Reset in the middle of a scan.
    tick();
    start = 1; start_idx = 8'd5; num_frags = CB'(20);
    tick();
    start = 0; fm_wait = 1;
    for (int j = 0; j < 5; j++) tick();
    chk("busy_in_scan", 64'(busy), 64'(1));
    #2 rst = 1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_valid", 64'(res_valid), 64'(0));
    chk("mid_rst_chg", 64'(chg_idx), 64'(0));
    chk("mid_rst_frag_idx", 64'(frag_idx), 64'(0));
    fm_wait = 0;
    tick();
    rst = 0;
    run_job(8'd3, 6, 1, 0);

    // Randomized windows, including wrapping and negative starts.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 128; i++) mem[i] = FL'({$urandom, $urandom, $urandom});
      run_job(IL'($urandom_range(0, 255)), int'($urandom_range(0, 24)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
